// File: rtl/decode_stall_buffer.sv
// Decode stall buffer: circular FIFO between fetch and decode, with the head held while stall=1.
// Optional performance counters (stall_cycles, occ_hwm) are built when DECODE_BUF_PERF_EN is defined.
module decode_stall_buffer #(
  parameter int DEPTH    = 2,
  parameter int UINSTR_W = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         valid_fe1,
  input  logic [UINSTR_W-1:0]          uinstr_fe1,
  output logic                         ready_fe1,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         valid_de0,
  output logic [UINSTR_W-1:0]          uinstr_de0,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef DECODE_BUF_PERF_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [$clog2(DEPTH+1)-1:0]   occ_hwm
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [OCC_W-1:0]    count;
  logic [UINSTR_W-1:0] mem [DEPTH];
  logic                enq;
  logic                deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // ready depends only on registered count and flush, never on stall or valid_fe1
  always_comb begin
    ready_fe1  = (count < OCC_W'(DEPTH)) & ~flush;
    valid_de0  = (count != '0);
    uinstr_de0 = mem[rd_ptr];
    occupancy  = count;
    enq        = valid_fe1 & ready_fe1;
    deq        = valid_de0 & ~stall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= uinstr_fe1;
  end

`ifdef DECODE_BUF_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      occ_hwm      <= '0;
    end else begin
      if (valid_de0 && stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (count > occ_hwm) occ_hwm <= count;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stall_buffer.sv
// Self-checking bench for decode_stall_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_decode_stall_buffer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_fe1 = 1'b0;
  logic [31:0] uinstr_fe1 = '0;
  logic        ready_fe1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid_de0;
  logic [31:0] uinstr_de0;
  logic [1:0]  occupancy;
`ifdef DECODE_BUF_PERF_EN
  logic [31:0] stall_cycles;
  logic [1:0]  occ_hwm;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit          exp_valid;
  bit          exp_ready;
  int          exp_occ;
  logic [31:0] exp_head;

  decode_stall_buffer #(.DEPTH(DEPTH), .UINSTR_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_fe1  (valid_fe1),
    .uinstr_fe1 (uinstr_fe1),
    .ready_fe1  (ready_fe1),
    .stall      (stall),
    .flush      (flush),
    .valid_de0  (valid_de0),
    .uinstr_de0 (uinstr_de0),
    .occupancy  (occupancy)
`ifdef DECODE_BUF_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .occ_hwm      (occ_hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic predict();
    exp_occ   = q.size();
    exp_valid = (q.size() != 0);
    exp_head  = exp_valid ? q[0] : '0;
    exp_ready = (q.size() < DEPTH) && !flush;
  endtask

  // Drive inputs after the falling edge, then form expectations from the model
  task automatic drive(input bit v, input logic [31:0] u, input bit s, input bit f);
    @(negedge clk);
    valid_fe1  = v;
    uinstr_fe1 = u;
    stall      = s;
    flush      = f;
    #1;
    predict();
  endtask

  // Advance the reference model across one rising edge
  task automatic model_edge();
    int n;
    bit acc;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      n   = q.size();
      acc = valid_fe1 && (n < DEPTH);
      if (n > 0 && !stall) void'(q.pop_front());
      if (acc) q.push_back(uinstr_fe1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; valid_fe1 = 1'b0; stall = 1'b0; flush = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; valid_fe1 = 1'b0; stall = 1'b0; flush = 1'b0;
    q.delete();
    #1;
    checks++;
    if (valid_de0 !== 1'b0 || occupancy !== 2'd0 || ready_fe1 !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b occ=%0d ready=%b, want valid=0 occ=0 ready=1",
               valid_de0, occupancy, ready_fe1);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_pipeline();
    logic [31:0] u;
    for (int c = 0; c < 5; c++) begin
      u = $urandom;
      drive(c < 3, u, 1'b0, 1'b0);
      checks++;
      if (valid_de0 !== exp_valid || occupancy !== exp_occ || ready_fe1 !== exp_ready ||
          occupancy > 2'd1 || (exp_valid && uinstr_de0 !== exp_head)) begin
        errors++;
        $display("FAIL pipeline c%0d: valid=%b/%b occ=%0d/%0d ready=%b/%b head=%h/%h", c,
                 valid_de0, exp_valid, occupancy, exp_occ, ready_fe1, exp_ready, uinstr_de0, exp_head);
      end
      model_edge();
    end
  endtask

  task automatic test_stall();
    bit          sv [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    bit          vv [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    int          sel[9] = '{0, 1, 2, 2, 2, 2, 0, 0, 0};
    logic [31:0] abc[3];
    for (int i = 0; i < 3; i++) abc[i] = $urandom;
    for (int c = 0; c < 9; c++) begin
      drive(vv[c], abc[sel[c]], sv[c], 1'b0);
      checks++;
      if (valid_de0 !== exp_valid || occupancy !== exp_occ || ready_fe1 !== exp_ready ||
          (exp_valid && uinstr_de0 !== exp_head) || ((c == 2 || c == 3) && ready_fe1 !== 1'b0)) begin
        errors++;
        $display("FAIL stall c%0d: valid=%b/%b occ=%0d/%0d ready=%b/%b head=%h/%h", c,
                 valid_de0, exp_valid, occupancy, exp_occ, ready_fe1, exp_ready, uinstr_de0, exp_head);
      end
      model_edge();
    end
  endtask

  task automatic test_full();
    bit          sv [6] = '{1, 1, 0, 0, 0, 0};
    bit          vv [6] = '{1, 1, 1, 1, 0, 0};
    logic [31:0] u;
    for (int c = 0; c < 6; c++) begin
      u = (c == 3) ? uinstr_fe1 : $urandom;
      drive(vv[c], u, sv[c], 1'b0);
      checks++;
      if (valid_de0 !== exp_valid || occupancy !== exp_occ || ready_fe1 !== exp_ready ||
          (exp_valid && uinstr_de0 !== exp_head) || (c == 2 && ready_fe1 !== 1'b0) ||
          (c == 3 && ready_fe1 !== 1'b1)) begin
        errors++;
        $display("FAIL full c%0d: valid=%b/%b occ=%0d/%0d ready=%b/%b head=%h/%h", c,
                 valid_de0, exp_valid, occupancy, exp_occ, ready_fe1, exp_ready, uinstr_de0, exp_head);
      end
      model_edge();
    end
  endtask

  task automatic test_flush();
    bit sv [5] = '{1, 0, 0, 0, 0};
    bit vv [5] = '{1, 1, 0, 0, 0};
    bit fv [5] = '{0, 1, 0, 0, 0};
    for (int c = 0; c < 5; c++) begin
      drive(vv[c], $urandom, sv[c], fv[c]);
      checks++;
      if (valid_de0 !== exp_valid || occupancy !== exp_occ || ready_fe1 !== exp_ready ||
          (exp_valid && uinstr_de0 !== exp_head) || (c >= 2 && valid_de0 !== 1'b0)) begin
        errors++;
        $display("FAIL flush c%0d: valid=%b/%b occ=%0d/%0d ready=%b/%b head=%h/%h", c,
                 valid_de0, exp_valid, occupancy, exp_occ, ready_fe1, exp_ready, uinstr_de0, exp_head);
      end
      model_edge();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0);
      model_edge();
    end
    @(negedge clk);
    valid_fe1 = 1'b0; stall = 1'b0;
    #2;
    reset_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (valid_de0 !== 1'b0 || occupancy !== 2'd0 || ready_fe1 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b occ=%0d ready=%b, want valid=0 occ=0 ready=1",
               valid_de0, occupancy, ready_fe1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (valid_de0 !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL post_reset c%0d: valid=%b occ=%0d, want valid=0 occ=0", c, valid_de0, occupancy);
      end
      model_edge();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(2, 0) != 0, $urandom, $urandom_range(2, 0) == 0, $urandom_range(15, 0) == 0);
      checks++;
      if (valid_de0 !== exp_valid || occupancy !== exp_occ || ready_fe1 !== exp_ready ||
          (exp_valid && uinstr_de0 !== exp_head)) begin
        errors++;
        $display("FAIL random c%0d: valid=%b/%b occ=%0d/%0d ready=%b/%b head=%h/%h", c,
                 valid_de0, exp_valid, occupancy, exp_occ, ready_fe1, exp_ready, uinstr_de0, exp_head);
      end
      model_edge();
    end
  endtask

`ifdef DECODE_BUF_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(c < 2, $urandom, 1'b1, 1'b0);
      model_edge();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (stall_cycles !== 32'd5 || occ_hwm !== 2'd2) begin
      errors++;
      $display("FAIL perf: stall_cycles=%0d occ_hwm=%0d, want 5 and 2", stall_cycles, occ_hwm);
    end
    model_edge();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (stall_cycles !== 32'd5 || occ_hwm !== 2'd2 || valid_de0 !== 1'b0) begin
      errors++;
      $display("FAIL perf_flush: stall_cycles=%0d occ_hwm=%0d valid=%b, want 5 2 0",
               stall_cycles, occ_hwm, valid_de0);
    end
    model_edge();
  endtask
`endif

  initial begin
    test_reset();
    test_pipeline();
    test_stall();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    do_reset();
    test_pipeline();
`ifdef DECODE_BUF_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stall_buffer.md
DECODE_STALL_BUFFER -- requirements
Module: decode_stall_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the number of buffer entries (legal values 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_fe1  input  1  a fetch uop is offered this cycle.
REQ-005 SHALL have port uinstr_fe1  input  t_uinstr  the offered uop.
REQ-006 SHALL have port ready_fe1  output  1  the buffer accepts the offered uop this cycle.
REQ-007 SHALL have port stall  input  1  scoreboard hazard stall; the head uop must hold.
REQ-008 SHALL have port flush  input  1  discard all buffered uops.
REQ-009 SHALL have port valid_de0  output  1  the head uop is valid.
REQ-010 SHALL have port uinstr_de0  output  t_uinstr  the head uop; it is undefined when valid_de0=0.
REQ-011 SHALL have port occupancy  output  $clog2(DEPTH+1)  the current entry count.

Function
REQ-012 SHALL implement a circular FIFO with read and write pointers that wrap from DEPTH-1 to 0, plus an entry count.
REQ-013 SHALL drive ready_fe1 = (occupancy < DEPTH) & ~flush, derived only from registered state and flush, with no dependence on stall or valid_fe1.
REQ-014 SHALL enqueue uinstr_fe1 at the write pointer when valid_fe1 & ready_fe1 is true, and advance the write pointer.
REQ-015 SHALL drive valid_de0 = (occupancy != 0) and drive uinstr_de0 from the entry at the read pointer.
REQ-016 SHALL dequeue, advancing the read pointer, when valid_de0 & ~stall is true.
REQ-017 SHALL keep uinstr_de0 stable, without advancing the read pointer, while stall=1 and valid_de0=1.
REQ-018 SHALL have a latency of one cycle: a uop enqueued in cycle N into an empty buffer is presented on valid_de0/uinstr_de0 in cycle N+1, with no same-cycle bypass.
REQ-019 SHALL leave occupancy unchanged on a simultaneous enqueue and dequeue and advance both pointers.
REQ-020 SHALL NOT accept an enqueue when full (ready_fe1=0), even if a dequeue occurs in the same cycle.
REQ-021 SHALL ignore a dequeue condition when empty and leave the pointers unchanged.
REQ-022 SHALL, when flush=1, set occupancy and both pointers to 0 on the next edge, with flush taking priority over enqueue and dequeue in the same cycle.
REQ-023 SHALL treat a stall while empty as a no-op and continue to accept enqueues while not full.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously clear the pointers and occupancy so that valid_de0=0, occupancy=0 and ready_fe1=1 (flush permitting).
REQ-025 SHALL NOT reset the entry payload storage.
REQ-026 SHALL, on reset assertion mid-operation, drop all entries immediately, with no uop presented after reset_n is released.

Configuration
REQ-027 SHALL, when DECODE_BUF_PERF_EN is defined, add output stall_cycles (32 bits), a saturating counter that increments each cycle valid_de0 & stall is true.
REQ-028 SHALL, when DECODE_BUF_PERF_EN is defined, add output occ_hwm ($clog2(DEPTH+1) bits), which records the maximum occupancy since reset.
REQ-029 SHALL, when DECODE_BUF_PERF_EN is defined, reset both added outputs to 0 and leave them unaffected by flush.
REQ-030 SHALL, when DECODE_BUF_PERF_EN is undefined, have neither output nor any counter logic, with all other behaviour identical.

Verification
REQ-031 SHALL cover: with DEPTH=2, offer uops A, B, C in consecutive cycles with stall=0 -> all are accepted and appear on de0 in cycles 1, 2 and 3, with occupancy never exceeding 1.
REQ-032 SHALL cover: hold stall=1 for 4 cycles while offering A, B, C -> A and B are buffered, ready_fe1=0 from cycle 2, C is held off, and after stall drops A, B, C emerge in order.
REQ-033 SHALL cover: when full (occupancy=2) with stall=0 and valid_fe1=1 -> one dequeue occurs, the offer is rejected that cycle and accepted the next cycle.
REQ-034 SHALL cover: when occupancy=1 and flush=1 coincides with valid_fe1=1 -> occupancy=0 next cycle, valid_de0=0, and the offered uop is dropped.
REQ-035 SHALL cover: with occupancy=2, assert reset_n=0 mid-cycle -> valid_de0 and occupancy drop to 0 before the next edge.
REQ-036 SHALL cover: with DECODE_BUF_PERF_EN defined, 5 stall cycles with a valid head -> stall_cycles=5 and occ_hwm=2.
